// File: rtl/core_pc_pkg.sv
// Shared constants and types for the multithreaded PC unit.
package core_pc_pkg;

    typedef enum logic [1:0] {
        REDIR_BR   = 2'b00,
        REDIR_J    = 2'b01,
        REDIR_EXC  = 2'b10,
        REDIR_ERET = 2'b11
    } redir_src_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/core_mt_pc_rr_next_thr.sv
// Circular priority finder: first enabled thread after cur_thr, wrapping back to cur_thr itself.
module rr_next_thr #(
    parameter int unsigned NUM_THR = 4,
    parameter int unsigned THR_W   = 2
) (
    input  logic [NUM_THR-1:0] thr_en,
    input  logic [THR_W-1:0]   cur_thr,
    output logic [THR_W-1:0]   next_thr,
    output logic               any_en
);

    logic [THR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest enabled thread wins.
    always_comb begin
        next_thr = cur_thr;
        any_en   = |thr_en;
        idx      = '0;
        for (int off = int'(NUM_THR); off > 0; off--) begin
            idx = THR_W'((int'(cur_thr) + off) % int'(NUM_THR));
            if (thr_en[idx]) begin
                next_thr = idx;
            end
        end
    end

endmodule

// File: rtl/core_mt_pc.sv
// Multithreaded program-counter unit: per-thread PC/EPC, round-robin fetch issue, redirects.
module core_mt_pc
    import core_pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       NUM_THR    = 4,
    parameter int unsigned       THR_W      = (NUM_THR > 1) ? $clog2(NUM_THR) : 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] THR_STRIDE = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h0000_0180)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_THR-1:0] thr_en,
    input  logic               stall,
    input  logic               fetch_rdy,
    input  logic               redir_valid,
    input  logic [THR_W-1:0]   redir_thr,
    input  logic [1:0]         redir_src,
    input  logic [ADDR_W-1:0]  redir_addr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [THR_W-1:0]   pc_thr,
    output logic               v_pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [ADDR_W-1:0]  epc_out
);

    logic [ADDR_W-1:0] pc_q  [NUM_THR];
    logic [ADDR_W-1:0] pc_d  [NUM_THR];
    logic [ADDR_W-1:0] epc_q [NUM_THR];
    logic [ADDR_W-1:0] epc_d [NUM_THR];
    logic [THR_W-1:0]  cur_thr_q;
    logic [THR_W-1:0]  cur_thr_d;

    logic              fire;
    logic              redir_ok;
    logic              advance;
    logic [THR_W-1:0]  rr_next;
    logic              rr_any;
    logic [ADDR_W-1:0] redir_aligned;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^redir_addr[1:0];
    assign redir_aligned   = {redir_addr[ADDR_W-1:2], 2'b00};

    rr_next_thr #(
        .NUM_THR (NUM_THR),
        .THR_W   (THR_W)
    ) u_rr_next_thr (
        .thr_en   (thr_en),
        .cur_thr  (cur_thr_q),
        .next_thr (rr_next),
        .any_en   (rr_any)
    );

    assign pc_out   = pc_q[cur_thr_q];
    assign pc_thr   = cur_thr_q;
    assign pc_plus4 = pc_out + ADDR_W'(PC_INC);
    assign v_pc_out = !rst && !stall && thr_en[cur_thr_q];
    assign fire     = v_pc_out && fetch_rdy;
    assign redir_ok = redir_valid && (32'(redir_thr) < NUM_THR);

    // Rotate on a completed fetch, or skip past a disabled current thread without issuing.
    assign advance  = !stall && (fire || !thr_en[cur_thr_q]);

    // EPC read port follows redir_thr so commit logic can fetch the return target.
    always_comb begin
        epc_out = '0;
        for (int t = 0; t < int'(NUM_THR); t++) begin
            if (redir_thr == THR_W'(t)) begin
                epc_out = epc_q[t];
            end
        end
    end

    // Next-state for PC/EPC: sequential increment first, a redirect on the same thread overrides it.
    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        cur_thr_d = cur_thr_q;

        for (int t = 0; t < int'(NUM_THR); t++) begin
            if (fire && (cur_thr_q == THR_W'(t))) begin
                pc_d[t] = pc_q[t] + ADDR_W'(PC_INC);
            end
            if (redir_ok && (redir_thr == THR_W'(t))) begin
                case (redir_src_e'(redir_src))
                    REDIR_BR,
                    REDIR_J:    pc_d[t] = redir_aligned;
                    REDIR_EXC: begin
                        epc_d[t] = redir_aligned;
                        pc_d[t]  = EXC_VEC;
                    end
                    REDIR_ERET: pc_d[t] = epc_q[t];
                    default:    pc_d[t] = pc_q[t];
                endcase
            end
        end

        if (advance && rr_any) begin
            cur_thr_d = rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < int'(NUM_THR); t++) begin
                pc_q[t]  <= RESET_ADDR + ADDR_W'(t) * THR_STRIDE;
                epc_q[t] <= '0;
            end
            cur_thr_q <= '0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cur_thr_q <= cur_thr_d;
        end
    end

endmodule

// File: tb/tb_core_mt_pc.sv
// Directed and randomized bench for core_mt_pc against a behavioural thread/PC model.
module tb_core_mt_pc;

    logic        clk;
    logic        rst;
    logic [3:0]  thr_en;
    logic        stall;
    logic        fetch_rdy;
    logic        redir_valid;
    logic [1:0]  redir_thr;
    logic [1:0]  redir_src;
    logic [31:0] redir_addr;
    logic [31:0] pc_out;
    logic [1:0]  pc_thr;
    logic        v_pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] epc_out;

    int          tests;
    int          fails;

    logic [31:0] pc_m  [4];
    logic [31:0] epc_m [4];
    int          cur_m;

    core_mt_pc dut (
        .clk         (clk),
        .rst         (rst),
        .thr_en      (thr_en),
        .stall       (stall),
        .fetch_rdy   (fetch_rdy),
        .redir_valid (redir_valid),
        .redir_thr   (redir_thr),
        .redir_src   (redir_src),
        .redir_addr  (redir_addr),
        .pc_out      (pc_out),
        .pc_thr      (pc_thr),
        .v_pc_out    (v_pc_out),
        .pc_plus4    (pc_plus4),
        .epc_out     (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int next_enabled(input int c, input logic [3:0] en);
        for (int k = 1; k <= 4; k++) begin
            if (en[(c + k) % 4]) return (c + k) % 4;
        end
        return c;
    endfunction

    // One clock: compare outputs with the model, take the edge, advance the model.
    task automatic cycle();
        logic        exp_v;
        logic        fire;
        logic [31:0] npc  [4];
        logic [31:0] nepc [4];
        #1;
        if (rst) begin
            chk("v_in_reset", 32'(v_pc_out), 32'd0);
        end else begin
            exp_v = !stall && thr_en[cur_m];
            chk("v_pc_out", 32'(v_pc_out), 32'(exp_v));
            chk("pc_thr", 32'(pc_thr), 32'(cur_m));
            chk("pc_out", pc_out, pc_m[cur_m]);
            chk("pc_plus4", pc_plus4, pc_m[cur_m] + 32'd4);
            chk("epc_out", epc_out, epc_m[redir_thr]);
        end
        @(posedge clk);
        if (rst) begin
            for (int t = 0; t < 4; t++) begin
                pc_m[t]  = 32'(t) * 32'h1000;
                epc_m[t] = 32'd0;
            end
            cur_m = 0;
        end else begin
            fire = !stall && thr_en[cur_m] && fetch_rdy;
            npc  = pc_m;
            nepc = epc_m;
            if (fire) npc[cur_m] = pc_m[cur_m] + 32'd4;
            if (redir_valid) begin
                case (redir_src)
                    2'd0, 2'd1: npc[redir_thr] = redir_addr & ~32'd3;
                    2'd2: begin
                        nepc[redir_thr] = redir_addr & ~32'd3;
                        npc[redir_thr]  = 32'h180;
                    end
                    default: npc[redir_thr] = epc_m[redir_thr];
                endcase
            end
            if (!stall && (fire || !thr_en[cur_m])) cur_m = next_enabled(cur_m, thr_en);
            pc_m  = npc;
            epc_m = nepc;
        end
        @(negedge clk);
    endtask

    // Run until thread t is current and issuing, bounded.
    task automatic wait_thr(input int t, input string tag);
        int n;
        n = 0;
        #1;
        while (!(v_pc_out && (32'(pc_thr) == 32'(t))) && n < 30) begin
            cycle();
            n++;
            #1;
        end
        chk(tag, 32'(n < 30), 32'd1);
    endtask

    task automatic redirect(input int t, input logic [1:0] src, input logic [31:0] addr);
        redir_valid = 1'b1;
        redir_thr   = 2'(t);
        redir_src   = src;
        redir_addr  = addr;
        cycle();
        redir_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] held;
        tests       = 0;
        fails       = 0;
        cur_m       = 0;
        rst         = 1'b1;
        thr_en      = 4'b1111;
        stall       = 1'b0;
        fetch_rdy   = 1'b1;
        redir_valid = 1'b0;
        redir_thr   = 2'd0;
        redir_src   = 2'd0;
        redir_addr  = 32'd0;

        cycle();
        cycle();
        rst = 1'b0;

        // Plain round-robin after reset.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_thr", 32'(pc_thr), 32'(i % 4));
            chk("rr_pc", pc_out, (i == 4) ? 32'h4 : 32'(i) * 32'h1000);
            cycle();
        end

        // Sparse enables with a held handshake on thread 2.
        thr_en = 4'b0101;
        cycle();
        cycle();
        cycle();
        fetch_rdy = 1'b0;
        #1;
        chk("hold_thr", 32'(pc_thr), 32'd2);
        chk("hold_pc", pc_out, 32'h2008);
        cycle();
        cycle();
        #1;
        chk("hold_thr2", 32'(pc_thr), 32'd2);
        chk("hold_pc2", pc_out, 32'h2008);
        fetch_rdy = 1'b1;
        cycle();
        #1;
        chk("after_hold_thr", 32'(pc_thr), 32'd0);

        // Branch on the firing thread wins over the increment; low bits masked.
        thr_en = 4'b1111;
        wait_thr(1, "wait_t1");
        redirect(1, 2'd0, 32'h0000_2003);
        wait_thr(1, "wait_t1b");
        chk("br_masked", pc_out, 32'h2000);

        // Exception then exception return on thread 3.
        redirect(3, 2'd2, 32'h3008);
        redir_thr = 2'd3;
        #1;
        chk("epc_t3", epc_out, 32'h3008);
        wait_thr(3, "wait_t3");
        chk("exc_vec", pc_out, 32'h180);
        redirect(3, 2'd3, 32'h0);
        wait_thr(3, "wait_t3b");
        chk("eret_pc", pc_out, 32'h3008);

        // Stall freezes issue and rotation; the jump still lands.
        stall = 1'b1;
        #1;
        held = pc_thr;
        redirect(0, 2'd1, 32'h500);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_v", 32'(v_pc_out), 32'd0);
            chk("stall_thr", 32'(pc_thr), 32'(held));
            cycle();
        end
        stall = 1'b0;
        wait_thr(0, "wait_t0");
        chk("jump_pc", pc_out, 32'h500);

        // No thread enabled, then a mid-stream reset.
        thr_en = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("none_v", 32'(v_pc_out), 32'd0);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_thr", 32'(pc_thr), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        thr_en = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("rst_rr_pc", pc_out, 32'(t) * 32'h1000);
            cycle();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            thr_en      = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            stall       = ($urandom_range(0, 4) == 0);
            fetch_rdy   = ($urandom_range(0, 3) != 0);
            redir_valid = ($urandom_range(0, 3) == 0);
            redir_thr   = 2'($urandom);
            redir_src   = 2'($urandom);
            redir_addr  = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
